// File: rtl/sync_ram_2p.sv
// Simple-dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write policy, optional output register and a zero-fill clear engine.
module sync_ram_2p #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clearStart,
  output logic                    busy,
  input  logic                    writeEnable,
  input  logic [ADDR_WIDTH-1:0]   writeAddress,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  input  logic                    readEnable,
  input  logic [ADDR_WIDTH-1:0]   readAddress,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic                    readValid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clearCount;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   readWord;
  logic [DATA_WIDTH-1:0]   rdData1;
  logic                    rdValid1;
  logic                    userAccept;
  logic                    writeAccept;
  logic                    readAccept;

  // A clear request in the same cycle as a user access wins; the access is dropped.
  assign userAccept  = (state == IDLE) && !clearStart;
  assign writeAccept = userAccept && writeEnable;
  assign readAccept  = userAccept && readEnable;
  assign busy        = (state == CLEAR);

  // Clear engine: one word per cycle, exactly DEPTH cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clearCount <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clearCount <= clearCount + ADDR_WIDTH'(1);
          if (&clearCount) state <= IDLE;
        end
        IDLE: begin
          if (clearStart) begin
            state      <= CLEAR;
            clearCount <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset branch so it maps onto RAM macros; contents
  // are zeroed by the clear engine instead.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clearCount] <= '0;
    end else if (writeAccept) begin
      for (int i = 0; i < LANES; i++) begin
        if (byteEnable[i]) mem[writeAddress][8*i +: 8] <= writeData[8*i +: 8];
      end
    end
  end

  // NOTE: readWord takes a full default before any conditional override so
  // no latch is inferred.
  always_comb begin
    readWord = mem[readAddress];
    if (RD_MODE == 1 && writeAccept && (writeAddress == readAddress)) begin
      for (int i = 0; i < LANES; i++) begin
        if (byteEnable[i]) readWord[8*i +: 8] = writeData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdData1  <= '0;
      rdValid1 <= 1'b0;
    end else begin
      rdValid1 <= readAccept;
      if (readAccept) rdData1 <= readWord;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outReg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          readData  <= '0;
          readValid <= 1'b0;
        end else begin
          readValid <= rdValid1;
          if (rdValid1) readData <= rdData1;
        end
      end
    end else begin : g_noOutReg
      assign readData  = rdData1;
      assign readValid = rdValid1;
    end
  endgenerate

endmodule

// File: tb/tb_sync_ram_2p.sv
// Directed bench for sync_ram_2p: instance A is read-first/latency 1,
// instance B is write-first/latency 2; both share the same stimulus.
module tb_sync_ram_2p;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clearStart = 1'b0;
  logic        writeEnable = 1'b0;
  logic [3:0]  writeAddress = '0;
  logic [15:0] writeData = '0;
  logic [1:0]  byteEnable = '0;
  logic        readEnable = 1'b0;
  logic [3:0]  readAddress = '0;

  logic        busyA, busyB, readValidA, readValidB;
  logic [15:0] readDataA, readDataB;

  int vectors = 0;
  int miscompares = 0;

  sync_ram_2p #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_MODE(0), .OUT_REG(0)) dutA (
    .clock(clock), .reset(reset), .clearStart(clearStart), .busy(busyA),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .byteEnable(byteEnable), .readEnable(readEnable), .readAddress(readAddress),
    .readData(readDataA), .readValid(readValidA)
  );

  sync_ram_2p #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_MODE(1), .OUT_REG(1)) dutB (
    .clock(clock), .reset(reset), .clearStart(clearStart), .busy(busyB),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .byteEnable(byteEnable), .readEnable(readEnable), .readAddress(readAddress),
    .readData(readDataB), .readValid(readValidB)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    writeEnable = 1'b1; writeAddress = a; writeData = d; byteEnable = be;
    tick();
    writeEnable = 1'b0; byteEnable = 2'b00;
  endtask

  // pat = {validA@+1, validB@+1, validA@+2, validB@+2}; a clean read gives 4'b1001.
  task automatic readBoth(input logic [3:0] a, output logic [15:0] dA, output logic [15:0] dB,
                          output logic [3:0] pat);
    readEnable = 1'b1; readAddress = a;
    tick();
    readEnable = 1'b0;
    pat[3] = readValidA; pat[2] = readValidB; dA = readDataA;
    tick();
    pat[1] = readValidA; pat[0] = readValidB; dB = readDataB;
  endtask

  // Counts samples with busy high, starting now; bounded so a stuck busy cannot hang.
  task automatic countBusy(output int nA, output int nB, output logic anyValid);
    nA = 0; nB = 0; anyValid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busyA) nA++;
      if (busyB) nB++;
      if (readValidA || readValidB) anyValid = 1'b1;
      if (!busyA && !busyB) break;
      tick();
    end
  endtask

  task automatic readAllZero(input string tag);
    logic [15:0] dA, dB;
    logic [3:0]  pat;
    for (int a = 0; a < 16; a++) begin
      readBoth(4'(a), dA, dB, pat);
      vectors++;
      if (dA !== 16'h0000 || dB !== 16'h0000 || pat !== 4'b1001) begin
        miscompares++;
        $display("FAIL %s addr %0d: got A=%h B=%h valid=%b expected A=0000 B=0000 valid=1001",
                 tag, a, dA, dB, pat);
      end
    end
  endtask

  task automatic test_reset();
    int nA, nB;
    logic anyValid;
    repeat (3) tick();
    vectors++;
    if ({busyA, busyB, readValidA, readValidB} !== 4'b1100 || readDataA !== 16'h0 || readDataB !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b%b valid=%b%b A=%h B=%h expected busy=11 valid=00 data=0",
               busyA, busyB, readValidA, readValidB, readDataA, readDataB);
    end
    reset = 1'b0;
    countBusy(nA, nB, anyValid);
    vectors++;
    if (nA !== 16 || nB !== 16 || anyValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_clear_len: got A=%0d B=%0d valid=%b expected 16 16 0", nA, nB, anyValid);
    end
    readAllZero("reset_zero");
  endtask

  task automatic test_write_lanes();
    logic [15:0] dA, dB;
    logic [3:0]  pat;
    writeWord(4'd3, 16'hABCD, 2'b11);
    writeWord(4'd3, 16'h1234, 2'b01);
    readBoth(4'd3, dA, dB, pat);
    vectors++;
    if (dA !== 16'hAB34 || dB !== 16'hAB34) begin
      miscompares++;
      $display("FAIL lanes_merge: got A=%h B=%h expected AB34", dA, dB);
    end
    vectors++;
    if (pat !== 4'b1001) begin
      miscompares++;
      $display("FAIL read_latency: got %b expected 1001", pat);
    end
    writeWord(4'd3, 16'hFFFF, 2'b00);
    readBoth(4'd3, dA, dB, pat);
    vectors++;
    if (dA !== 16'hAB34 || dB !== 16'hAB34) begin
      miscompares++;
      $display("FAIL be_zero_noop: got A=%h B=%h expected AB34", dA, dB);
    end
  endtask

  task automatic collide(input logic [15:0] d, input logic [1:0] be,
                         input logic [15:0] expA, input logic [15:0] expB, input string tag);
    logic vA, vB;
    logic [15:0] dA, dB;
    writeEnable = 1'b1; writeAddress = 4'd5; writeData = d; byteEnable = be;
    readEnable = 1'b1; readAddress = 4'd5;
    tick();
    writeEnable = 1'b0; byteEnable = 2'b00; readEnable = 1'b0;
    vA = readValidA; dA = readDataA;
    tick();
    vB = readValidB; dB = readDataB;
    vectors++;
    if (vA !== 1'b1 || dA !== expA) begin
      miscompares++;
      $display("FAIL %s_A: got valid=%b data=%h expected 1 %h", tag, vA, dA, expA);
    end
    vectors++;
    if (vB !== 1'b1 || dB !== expB) begin
      miscompares++;
      $display("FAIL %s_B: got valid=%b data=%h expected 1 %h", tag, vB, dB, expB);
    end
  endtask

  task automatic test_collision();
    logic [15:0] dA, dB;
    logic [3:0]  pat;
    writeWord(4'd5, 16'h1111, 2'b11);
    collide(16'h2222, 2'b11, 16'h1111, 16'h2222, "collide_full");
    readBoth(4'd5, dA, dB, pat);
    vectors++;
    if (dA !== 16'h2222 || dB !== 16'h2222) begin
      miscompares++;
      $display("FAIL collide_after: got A=%h B=%h expected 2222", dA, dB);
    end
    collide(16'h4444, 2'b10, 16'h2222, 16'h4422, "collide_lane");
    readBoth(4'd5, dA, dB, pat);
    vectors++;
    if (dA !== 16'h4422 || dB !== 16'h4422) begin
      miscompares++;
      $display("FAIL collide_lane_after: got A=%h B=%h expected 4422", dA, dB);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] got [4];
    logic [17:0] exp [4];
    for (int i = 0; i < 16; i++) writeWord(4'(i), {4'h0, 4'(i), 4'h0, 4'(i)}, 2'b11);
    readEnable = 1'b1; readAddress = 4'd15;
    tick();
    readAddress = 4'd0;
    got[0] = {readValidA, readValidB, readDataA};
    tick();
    readEnable = 1'b0;
    got[1] = {readValidA, readValidB, readDataA};
    got[2] = {readValidA, readValidB, readDataB};
    tick();
    got[3] = {readValidA, readValidB, readDataB};
    exp[0] = {2'b10, 16'h0F0F};
    exp[1] = {2'b11, 16'h0000};
    exp[2] = {2'b11, 16'h0F0F};
    exp[3] = {2'b01, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k] !== exp[k]) begin
        miscompares++;
        $display("FAIL b2b_step%0d: got valid=%b data=%h expected valid=%b data=%h",
                 k, got[k][17:16], got[k][15:0], exp[k][17:16], exp[k][15:0]);
      end
    end
    tick();
    vectors++;
    if (readValidB !== 1'b0 || readDataB !== 16'h0000 || readDataA !== 16'h0000) begin
      miscompares++;
      $display("FAIL b2b_hold: got validB=%b A=%h B=%h expected 0 0000 0000",
               readValidB, readDataA, readDataB);
    end
  endtask

  task automatic test_clear_request();
    int nA, nB;
    logic anyValid;
    clearStart = 1'b1;
    writeEnable = 1'b1; writeAddress = 4'd2; writeData = 16'hFFFF; byteEnable = 2'b11;
    readEnable = 1'b1; readAddress = 4'd15;
    tick();
    clearStart = 1'b0; writeEnable = 1'b0; byteEnable = 2'b00; readEnable = 1'b0;
    countBusy(nA, nB, anyValid);
    vectors++;
    if (nA !== 16 || nB !== 16 || anyValid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_req_len: got A=%0d B=%0d valid=%b expected 16 16 0", nA, nB, anyValid);
    end
    readAllZero("clear_req_zero");
  endtask

  task automatic test_reset_mid_read();
    int nA, nB;
    logic anyValid;
    writeWord(4'd7, 16'h7777, 2'b11);
    readEnable = 1'b1; readAddress = 4'd7;
    tick();
    readEnable = 1'b0;
    vectors++;
    if (readValidA !== 1'b1 || readDataA !== 16'h7777) begin
      miscompares++;
      $display("FAIL pre_reset_read: got %b %h expected 1 7777", readValidA, readDataA);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busyA, busyB, readValidA, readValidB} !== 4'b1100 || readDataA !== 16'h0 || readDataB !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid_read: got busy=%b%b valid=%b%b A=%h B=%h expected 11 00 0 0",
               busyA, busyB, readValidA, readValidB, readDataA, readDataB);
    end
    tick();
    tick();
    reset = 1'b0;
    countBusy(nA, nB, anyValid);
    vectors++;
    if (nA !== 16 || nB !== 16 || anyValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_read_clear: got A=%0d B=%0d valid=%b expected 16 16 0", nA, nB, anyValid);
    end
  endtask

  task automatic test_reset_mid_clear();
    int nA, nB;
    logic anyValid;
    logic [15:0] dA, dB;
    logic [3:0]  pat;
    writeWord(4'd12, 16'h5A5A, 2'b11);
    clearStart = 1'b1;
    tick();
    clearStart = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (busyA !== 1'b1 || busyB !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_clear_busy: got %b%b expected 11", busyA, busyB);
    end
    reset = 1'b0;
    countBusy(nA, nB, anyValid);
    vectors++;
    if (nA !== 16 || nB !== 16) begin
      miscompares++;
      $display("FAIL reset_mid_clear_len: got A=%0d B=%0d expected 16 16", nA, nB);
    end
    readBoth(4'd12, dA, dB, pat);
    vectors++;
    if (dA !== 16'h0000 || dB !== 16'h0000 || pat !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_mid_clear_addr12: got A=%h B=%h valid=%b expected 0000 0000 1001", dA, dB, pat);
    end
  endtask

  initial begin
    test_reset();
    test_write_lanes();
    test_collision();
    test_back_to_back();
    test_clear_request();
    test_reset_mid_read();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
